clause_evaluator: RTL and testbench
===================================

// Module: clause_evaluator
// PURPOSE
//  Consumer stage directly downstream of the static clause memory. Takes one row
//  per cycle: NUM_CLAUSES_PER_CYCLE clauses, NUM_VARS_PER_CLAUSE literals each.
//  Evaluates every clause against a snapshotted variable assignment.
//  Accumulates one full sweep of NUM_CLAUSES clauses into a single verdict for the
//  search controller: all-SAT, conflict, or first unit literal.
// PARAMETERS
//  NUM_CLAUSES            64  total clauses; must be a multiple of NUM_CLAUSES_PER_CYCLE
//  VAR_ID_BITS            8   variable id width; NUM_VARS = 2**VAR_ID_BITS
//  NUM_CLAUSES_PER_CYCLE  16  clauses per input row
//  NUM_VARS_PER_CLAUSE    3   literals per clause
//  (derived) ROWS = NUM_CLAUSES/NUM_CLAUSES_PER_CYCLE; LIT_W = VAR_ID_BITS+1
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  start          in   1      begin a sweep; sampled only in IDLE
//  assign_valid   in   NUM_VARS    per-var assigned flag, snapshotted on accepted start
//  assign_value   in   NUM_VARS    per-var value, snapshotted on accepted start
//  slice_valid    in   1      slice_in/slice_row are meaningful this cycle
//  slice_row      in   $clog2(ROWS)  row index of slice_in
//  slice_in       in   LIT_W*NUM_VARS_PER_CLAUSE*NUM_CLAUSES_PER_CYCLE  clause row
//  busy           out  1      high from accepted start until done
//  done           out  1      one-cycle pulse; result outputs valid, held until next start
//  sat_all        out  1      every clause satisfied
//  conflict       out  1      at least one clause has all literals false
//  conflict_idx   out  $clog2(NUM_CLAUSES)  lowest conflicting clause index
//  unit_found     out  1      at least one unit clause
//  unit_lit       out  LIT_W  forced literal of the lowest-index unit clause
//  seq_err        out  1      one-cycle pulse on out-of-order row
// BEHAVIOUR
//  Literal encoding: bit[VAR_ID_BITS] = negated; bits[VAR_ID_BITS-1:0] = var id.
//   Var id 0 marks an empty slot, ignored. Clause index = row*NUM_CLAUSES_PER_CYCLE + slot.
//   Slot 0 is the LSBs; literal 0 is the LSBs within its clause.
//  Literal state: UNASSIGNED if !assign_valid[id]; TRUE if valid && (value != neg);
//   otherwise FALSE.
//  Clause status:
//   - SAT if any literal TRUE, or if all slots are empty.
//   - CONFLICT if no TRUE literal and 0 UNASSIGNED.
//   - UNIT if no TRUE literal and exactly 1 UNASSIGNED.
//   - else OPEN.
//  FSM IDLE->ARM->SWEEP->FLUSH->IDLE:
//   - IDLE: start=1 snapshots assignment, clears results, busy<=1, ->ARM.
//   - ARM: waits for slice_valid && slice_row==0; captures row 0, ->SWEEP with expect=1.
//   - SWEEP: slice_valid=0 holds state. slice_valid && slice_row==expect captures
//     the row and increments expect. slice_valid && slice_row!=expect pulses seq_err,
//     discards partial results, ->ARM.
//   - SWEEP: capture of row ROWS-1 ->FLUSH.
//   - Single-row config (ROWS==1): ARM capture goes directly to FLUSH.
//   - FLUSH: per-clause status register drains, accumulators update.
//     done<=1 and busy<=0 on the following edge.
//  Pipeline: stage 1 registers per-clause status; stage 2 is the running
//   accumulation. Last row captured at edge N => done high in cycle after edge N+2.
//  Best-case latency start->done = ROWS+3 cycles (row 0 arriving on the start cycle+1).
//  Accumulation:
//   - sat_all = AND of SAT.
//   - conflict / unit_found = OR.
//   - conflict_idx and unit_lit keep the first (lowest-index) hit; later rows never
//     overwrite. Within a clause, unit_lit is the single UNASSIGNED literal, sign preserved.
//  Conflict and unit are reported independently; both may be 1.
//  start while busy is ignored. Assignment inputs changing mid-sweep have no effect.
//  Reset (any time, async): state=IDLE; busy, done, seq_err, sat_all, conflict,
//   unit_found = 0; conflict_idx, unit_lit = 0; pipeline valid bits cleared.
// STRUCTURE
//  Shared package sat_pkg:
//   - literal_t struct {logic neg; logic [VAR_ID_BITS-1:0] id;}
//   - clause_status_t enum {CL_OPEN, CL_SAT, CL_UNIT, CL_CONFLICT}
//   - EMPTY_VAR_ID = 0
//  Sub-module clause_status_unit: combinational, one clause + assignment
//   -> {status, unit literal}. Instantiated NUM_CLAUSES_PER_CYCLE times via generate.
//  This module owns the FSM, snapshot registers, pipeline and accumulators.
// TESTING (defaults; drive slices in order 0..3 with slice_valid=1)
//  1 All 64 clauses = (+1,+2,+3); assign var1=1, others unassigned; start
//    -> done at start+7, sat_all=1, conflict=0, unit_found=0.
//  2 Clause 37 = (-5,-5,-5) with var5=1; rest SAT -> conflict=1, conflict_idx=37, sat_all=0.
//  3 Clause 20 = (+7,-8,0) with var8=1, var7 unassigned; clause 50 also unit on -9
//    -> unit_found=1, unit_lit={0,8'd7}.
//  4 Drop slice_valid for 3 cycles after row 1 -> done delayed exactly 3 cycles,
//    same result as 1.
//  5 Rows sent 0,1,3 -> seq_err pulse at row 3, busy stays 1.
//    Then 0..3 -> correct done.
//  6 Assert rst during SWEEP -> all outputs 0 immediately. start pulsed while busy
//    in a separate run -> no restart; done count = 1.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared types for the clause evaluation path: literal layout, clause status
// and the evaluator FSM encoding.
package sat_pkg;

    localparam int VAR_ID_BITS_DEF = 8;
    localparam int EMPTY_VAR_ID    = 0;

    typedef struct packed {
        logic                       neg;
        logic [VAR_ID_BITS_DEF-1:0] id;
    } literal_t;

    typedef enum logic [1:0] {
        CL_OPEN,
        CL_SAT,
        CL_UNIT,
        CL_CONFLICT
    } clause_status_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_SWEEP,
        ST_FLUSH
    } eval_state_t;

endpackage

// File: rtl/clause_status_unit.sv
// Combinational status of one clause against a variable assignment, plus the
// single unassigned literal when the clause is unit.
module clause_status_unit
    import sat_pkg::*;
#(
    parameter int VAR_ID_BITS         = 8,
    parameter int NUM_VARS_PER_CLAUSE = 3
) (
    input  logic [(VAR_ID_BITS+1)*NUM_VARS_PER_CLAUSE-1:0] clause,
    input  logic [2**VAR_ID_BITS-1:0]                      assign_valid,
    input  logic [2**VAR_ID_BITS-1:0]                      assign_value,
    output clause_status_t                                 status,
    output logic [VAR_ID_BITS:0]                           unit_lit
);

    localparam int LIT_W = VAR_ID_BITS + 1;
    localparam int CNT_W = $clog2(NUM_VARS_PER_CLAUSE + 1);

    logic [LIT_W-1:0]       lit;
    logic [VAR_ID_BITS-1:0] id;
    logic                   any_true;
    logic                   all_empty;
    logic [CNT_W-1:0]       n_unassigned;

    always_comb begin
        any_true     = 1'b0;
        all_empty    = 1'b1;
        n_unassigned = '0;
        unit_lit     = '0;
        lit          = '0;
        id           = '0;
        for (int i = 0; i < NUM_VARS_PER_CLAUSE; i++) begin
            lit = clause[i*LIT_W +: LIT_W];
            id  = lit[VAR_ID_BITS-1:0];
            if (id != VAR_ID_BITS'(EMPTY_VAR_ID)) begin
                all_empty = 1'b0;
                if (!assign_valid[id]) begin
                    n_unassigned = n_unassigned + 1'b1;
                    unit_lit     = lit;
                end else if (assign_value[id] != lit[VAR_ID_BITS]) begin
                    any_true = 1'b1;
                end
            end
        end

        // An all-empty clause places no constraint, so it counts as satisfied.
        if (any_true || all_empty) begin
            status = CL_SAT;
        end else if (n_unassigned == '0) begin
            status = CL_CONFLICT;
        end else if (n_unassigned == CNT_W'(1)) begin
            status = CL_UNIT;
        end else begin
            status = CL_OPEN;
        end
    end

endmodule

// File: rtl/clause_evaluator.sv
// Sweeps all clause rows from the clause memory against a snapshotted
// assignment and reduces them to one verdict: all-SAT, first conflict, first unit.
module clause_evaluator
    import sat_pkg::*;
#(
    parameter int NUM_CLAUSES           = 64,
    parameter int VAR_ID_BITS           = 8,
    parameter int NUM_CLAUSES_PER_CYCLE = 16,
    parameter int NUM_VARS_PER_CLAUSE   = 3,
    localparam int ROWS     = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
    localparam int LIT_W    = VAR_ID_BITS + 1,
    localparam int NUM_VARS = 2 ** VAR_ID_BITS,
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int IDX_W    = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1,
    localparam int CL_W     = LIT_W * NUM_VARS_PER_CLAUSE,
    localparam int ROW_BITS = CL_W * NUM_CLAUSES_PER_CYCLE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_VARS-1:0] assign_valid,
    input  logic [NUM_VARS-1:0] assign_value,
    input  logic                slice_valid,
    input  logic [ROW_W-1:0]    slice_row,
    input  logic [ROW_BITS-1:0] slice_in,
    output logic                busy,
    output logic                done,
    output logic                sat_all,
    output logic                conflict,
    output logic [IDX_W-1:0]    conflict_idx,
    output logic                unit_found,
    output logic [LIT_W-1:0]    unit_lit,
    output logic                seq_err,
    output logic [1:0]          state_dbg
);

    localparam int NCPC   = NUM_CLAUSES_PER_CYCLE;
    localparam int SLOT_W = (NCPC > 1) ? $clog2(NCPC) : 1;

    // Handshake: a row is transferred on any edge where slice_valid is high and
    // the FSM is in ARM or SWEEP; there is no ready, so the evaluator either
    // takes the row, waits for row 0 (ARM), or flags it as out of order.

    eval_state_t         state;
    eval_state_t         state_next;
    logic                accept_start;
    logic                capture;
    logic                discard;
    logic                finish;
    logic                last_row;

    logic [NUM_VARS-1:0] snap_valid;
    logic [NUM_VARS-1:0] snap_value;
    logic [ROW_W-1:0]    expect_row;

    clause_status_t      cl_status [NCPC];
    logic [LIT_W-1:0]    cl_unit   [NCPC];

    logic                st_valid;
    logic [ROW_W-1:0]    st_row;
    clause_status_t      st_status [NCPC];
    logic [LIT_W-1:0]    st_unit   [NCPC];

    logic                row_all_sat;
    logic                row_conf;
    logic [SLOT_W-1:0]   row_conf_slot;
    logic                row_unit;
    logic [LIT_W-1:0]    row_unit_lit;
    logic [IDX_W-1:0]    row_conf_idx;

    logic                acc_sat;
    logic                acc_conflict;
    logic [IDX_W-1:0]    acc_idx;
    logic                acc_unit;
    logic [LIT_W-1:0]    acc_lit;

    assign state_dbg = state;

    for (genvar g = 0; g < NCPC; g++) begin : g_clause
        clause_status_unit #(
            .VAR_ID_BITS         (VAR_ID_BITS),
            .NUM_VARS_PER_CLAUSE (NUM_VARS_PER_CLAUSE)
        ) u_status (
            .clause       (slice_in[g*CL_W +: CL_W]),
            .assign_valid (snap_valid),
            .assign_value (snap_value),
            .status       (cl_status[g]),
            .unit_lit     (cl_unit[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        capture      = 1'b0;
        discard      = 1'b0;
        finish       = 1'b0;
        last_row     = (slice_row == ROW_W'(ROWS - 1));
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = ST_ARM;
                end
            end
            ST_ARM: begin
                if (slice_valid && slice_row == '0) begin
                    capture    = 1'b1;
                    state_next = (ROWS == 1) ? ST_FLUSH : ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (slice_valid) begin
                    if (slice_row == expect_row) begin
                        capture = 1'b1;
                        if (last_row) begin
                            state_next = ST_FLUSH;
                        end
                    end else begin
                        discard    = 1'b1;
                        state_next = ST_ARM;
                    end
                end
            end
            ST_FLUSH: begin
                // Wait until the last row has left the status register.
                if (!st_valid) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Scan from the top slot down so the lowest-index hit is the one kept.
    always_comb begin
        row_all_sat   = 1'b1;
        row_conf      = 1'b0;
        row_conf_slot = '0;
        row_unit      = 1'b0;
        row_unit_lit  = '0;
        for (int s = NCPC - 1; s >= 0; s--) begin
            if (st_status[s] != CL_SAT) begin
                row_all_sat = 1'b0;
            end
            if (st_status[s] == CL_CONFLICT) begin
                row_conf      = 1'b1;
                row_conf_slot = SLOT_W'(s);
            end
            if (st_status[s] == CL_UNIT) begin
                row_unit     = 1'b1;
                row_unit_lit = st_unit[s];
            end
        end
    end

    assign row_conf_idx = IDX_W'(st_row) * IDX_W'(NCPC) + IDX_W'(row_conf_slot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            seq_err      <= 1'b0;
            sat_all      <= 1'b0;
            conflict     <= 1'b0;
            conflict_idx <= '0;
            unit_found   <= 1'b0;
            unit_lit     <= '0;
            snap_valid   <= '0;
            snap_value   <= '0;
            expect_row   <= '0;
            st_valid     <= 1'b0;
            st_row       <= '0;
            for (int s = 0; s < NCPC; s++) begin
                st_status[s] <= CL_OPEN;
                st_unit[s]   <= '0;
            end
            acc_sat      <= 1'b0;
            acc_conflict <= 1'b0;
            acc_idx      <= '0;
            acc_unit     <= 1'b0;
            acc_lit      <= '0;
        end else begin
            done     <= finish;
            seq_err  <= discard;
            st_valid <= capture;

            if (accept_start) begin
                busy         <= 1'b1;
                snap_valid   <= assign_valid;
                snap_value   <= assign_value;
                expect_row   <= '0;
                sat_all      <= 1'b0;
                conflict     <= 1'b0;
                conflict_idx <= '0;
                unit_found   <= 1'b0;
                unit_lit     <= '0;
            end

            if (capture) begin
                expect_row <= slice_row + 1'b1;
                st_row     <= slice_row;
                st_status  <= cl_status;
                st_unit    <= cl_unit;
            end

            // A fresh sweep and a restarted sweep both begin from a clean slate.
            if (accept_start || discard) begin
                acc_sat      <= 1'b1;
                acc_conflict <= 1'b0;
                acc_idx      <= '0;
                acc_unit     <= 1'b0;
                acc_lit      <= '0;
            end else if (st_valid) begin
                acc_sat <= acc_sat & row_all_sat;
                if (row_conf && !acc_conflict) begin
                    acc_conflict <= 1'b1;
                    acc_idx      <= row_conf_idx;
                end
                if (row_unit && !acc_unit) begin
                    acc_unit <= 1'b1;
                    acc_lit  <= row_unit_lit;
                end
            end

            if (finish) begin
                busy         <= 1'b0;
                sat_all      <= acc_sat;
                conflict     <= acc_conflict;
                conflict_idx <= acc_idx;
                unit_found   <= acc_unit;
                unit_lit     <= acc_lit;
            end
        end
    end

endmodule

// File: tb/tb_clause_evaluator.sv
// Directed bench for clause_evaluator: a sweep-level model of the clause
// memory and assignment predicts each verdict and its done cycle.
module tb_clause_evaluator;
    import sat_pkg::*;

    localparam int NC    = 64;
    localparam int NCPC  = 16;
    localparam int NVPC  = 3;
    localparam int ROWS  = 4;
    localparam int LIT_W = 9;
    localparam int NV    = 256;
    localparam int RW    = 2;
    localparam int IW    = 6;
    localparam int SW    = LIT_W * NVPC * NCPC;
    localparam int RES_W = 1 + 1 + IW + 1 + LIT_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NV-1:0] assign_valid;
    logic [NV-1:0] assign_value;
    logic          slice_valid;
    logic [RW-1:0] slice_row;
    logic [SW-1:0] slice_in;
    logic          busy, done, sat_all, conflict, unit_found, seq_err;
    logic [IW-1:0] conflict_idx;
    logic [LIT_W-1:0] unit_lit;
    logic [1:0]    state_dbg;

    clause_evaluator dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .assign_valid (assign_valid),
        .assign_value (assign_value),
        .slice_valid  (slice_valid),
        .slice_row    (slice_row),
        .slice_in     (slice_in),
        .busy         (busy),
        .done         (done),
        .sat_all      (sat_all),
        .conflict     (conflict),
        .conflict_idx (conflict_idx),
        .unit_found   (unit_found),
        .unit_lit     (unit_lit),
        .seq_err      (seq_err),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- model state ----------------
    literal_t mem [NC][NVPC];
    bit       mv   [NV];
    bit       mval [NV];

    logic [RES_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int done_count = 0;
    int seq_err_count = 0;
    int start_cyc = 0;
    int last_row_cyc = 0;
    int exp_done_cyc = 0;
    int done_cyc = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic literal_t mk(input bit neg, input int id);
        literal_t l;
        l.neg = neg;
        l.id  = 8'(id);
        return l;
    endfunction

    task automatic set_clause(input int c, input literal_t a, input literal_t b, input literal_t d);
        mem[c][0] = a;
        mem[c][1] = b;
        mem[c][2] = d;
    endtask

    task automatic fill_default();
        for (int c = 0; c < NC; c++) set_clause(c, mk(0, 1), mk(0, 2), mk(0, 3));
        for (int v = 0; v < NV; v++) begin
            mv[v]   = 1'b0;
            mval[v] = 1'b0;
        end
        mv[1]   = 1'b1;
        mval[1] = 1'b1;
    endtask

    // Whole-sweep verdict straight from the clause rules.
    function automatic logic [RES_W-1:0] model_result();
        bit       m_sat;
        bit       m_conf;
        bit       m_unit;
        int       m_idx;
        literal_t m_lit;
        int       n_true, n_un, n_used;
        literal_t free_lit;
        literal_t l;
        m_sat  = 1'b1;
        m_conf = 1'b0;
        m_unit = 1'b0;
        m_idx  = 0;
        m_lit  = '0;
        for (int c = 0; c < NC; c++) begin
            n_true   = 0;
            n_un     = 0;
            n_used   = 0;
            free_lit = '0;
            for (int i = 0; i < NVPC; i++) begin
                l = mem[c][i];
                if (l.id != 0) begin
                    n_used++;
                    if (!mv[l.id]) begin
                        n_un++;
                        free_lit = l;
                    end else if (mval[l.id] != l.neg) begin
                        n_true++;
                    end
                end
            end
            if (!(n_true > 0 || n_used == 0)) begin
                m_sat = 1'b0;
                if (n_un == 0 && !m_conf) begin
                    m_conf = 1'b1;
                    m_idx  = c;
                end
                if (n_un == 1 && !m_unit) begin
                    m_unit = 1'b1;
                    m_lit  = free_lit;
                end
            end
        end
        return {m_sat, m_conf, IW'(m_idx), m_unit, m_lit};
    endfunction

    function automatic logic [SW-1:0] pack_row(input int r);
        logic [SW-1:0] v;
        v = '0;
        for (int s = 0; s < NCPC; s++)
            for (int i = 0; i < NVPC; i++)
                v[(s*NVPC + i)*LIT_W +: LIT_W] = mem[r*NCPC + s][i];
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_start(input bit push);
        @(negedge clk);
        for (int v = 0; v < NV; v++) begin
            assign_valid[v] = mv[v];
            assign_value[v] = mval[v];
        end
        start     = 1'b1;
        start_cyc = cyc;
        if (push) exp_q.push_back(model_result());
        @(negedge clk);
        start = 1'b0;
        // Scramble the live assignment: only the snapshot may matter now.
        for (int w = 0; w < NV / 32; w++) begin
            assign_valid[w*32 +: 32] = $urandom();
            assign_value[w*32 +: 32] = $urandom();
        end
    endtask

    task automatic send_row(input int r);
        slice_valid  = 1'b1;
        slice_row    = RW'(r);
        slice_in     = pack_row(r);
        last_row_cyc = cyc;
        @(negedge clk);
        slice_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        slice_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int base);
        int k;
        k = 0;
        while (done_count == base && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done_count, base + 1);
        @(negedge clk);
    endtask

    task automatic run_full();
        int base;
        base = done_count;
        do_start(1'b1);
        for (int r = 0; r < ROWS; r++) send_row(r);
        exp_done_cyc = last_row_cyc + 3;
        wait_done(base);
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                logic [RES_W-1:0] got;
                logic [RES_W-1:0] want;
                done_count++;
                done_cyc = cyc;
                got = {sat_all, conflict, conflict_idx, unit_found, unit_lit};
                check("done_pulse_width", prev_done, 1'b0);
                check("done_latency", cyc, exp_done_cyc);
                check("busy_low_at_done", busy, 1'b0);
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 1'b1, 1'b0);
                end else begin
                    want = exp_q.pop_front();
                    check("sweep_result", got, want);
                end
            end
            if (seq_err) seq_err_count++;
            prev_done = done;
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        int base;
        rst = 1'b1;
        start = 1'b0;
        slice_valid = 1'b0;
        slice_row = '0;
        slice_in = '0;
        assign_valid = '0;
        assign_value = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, done, seq_err, sat_all, conflict, unit_found, conflict_idx, unit_lit}, 0);
        check("reset_state", state_dbg, 0);
        rst = 1'b0;
        idle(2);

        // 1: every clause satisfied via var1
        fill_default();
        run_full();
        check("t1_latency", done_cyc - start_cyc, 7);
        check("t1_sat_all", sat_all, 1'b1);
        check("t1_conflict", conflict, 1'b0);
        check("t1_unit", unit_found, 1'b0);

        // 2: single conflicting clause 37
        fill_default();
        set_clause(37, mk(1, 5), mk(1, 5), mk(1, 5));
        mv[5] = 1'b1; mval[5] = 1'b1;
        run_full();
        check("t2_conflict", conflict, 1'b1);
        check("t2_conflict_idx", conflict_idx, 37);
        check("t2_sat_all", sat_all, 1'b0);

        // 3: two unit clauses, lowest index wins
        fill_default();
        mv[8] = 1'b1; mval[8] = 1'b1;
        set_clause(20, mk(0, 7), mk(1, 8), mk(0, 0));
        set_clause(50, mk(1, 9), mk(1, 8), mk(0, 0));
        run_full();
        check("t3_unit_found", unit_found, 1'b1);
        check("t3_unit_lit", unit_lit, 9'd7);
        check("t3_conflict", conflict, 1'b0);

        // 4: three-cycle gap after row 1
        fill_default();
        base = done_count;
        do_start(1'b1);
        send_row(0);
        send_row(1);
        idle(3);
        send_row(2);
        send_row(3);
        exp_done_cyc = last_row_cyc + 3;
        wait_done(base);
        check("t4_latency", done_cyc - start_cyc, 10);
        check("t4_sat_all", sat_all, 1'b1);

        // 5: out-of-order row then a clean resend
        fill_default();
        set_clause(21, mk(1, 1), mk(1, 1), mk(1, 1));
        seq_err_count = 0;
        base = done_count;
        do_start(1'b1);
        send_row(0);
        send_row(1);
        send_row(3);
        check("t5_seq_err_pulse", seq_err, 1'b1);
        check("t5_busy_on_err", busy, 1'b1);
        send_row(0);
        check("t5_seq_err_clear", seq_err, 1'b0);
        check("t5_busy_after_err", busy, 1'b1);
        for (int r = 1; r < ROWS; r++) send_row(r);
        exp_done_cyc = last_row_cyc + 3;
        wait_done(base);
        check("t5_seq_err_count", seq_err_count, 1);
        check("t5_conflict_idx", conflict_idx, 21);

        // 6a: reset in the middle of a sweep
        fill_default();
        do_start(1'b1);
        send_row(0);
        send_row(1);
        check("t6_busy_mid", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_outputs",
              {busy, done, seq_err, sat_all, conflict, unit_found, conflict_idx, unit_lit}, 0);
        check("t6_rst_state", state_dbg, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        prev_done = 1'b0;
        idle(2);

        // 6b: start while busy must not restart
        fill_default();
        set_clause(40, mk(0, 30), mk(1, 1), mk(0, 0));
        base = done_count;
        do_start(1'b1);
        send_row(0);
        start = 1'b1;
        send_row(1);
        start = 1'b0;
        send_row(2);
        send_row(3);
        exp_done_cyc = last_row_cyc + 3;
        wait_done(base);
        idle(6);
        check("t6_done_count", done_count - base, 1);
        check("t6_unit_lit", unit_lit, 9'd30);

        // 7: empty clause is SAT, two-unassigned clause is open
        fill_default();
        set_clause(0, mk(0, 0), mk(0, 0), mk(0, 0));
        set_clause(5, mk(0, 10), mk(0, 11), mk(0, 0));
        run_full();
        check("t7_flags", {sat_all, conflict, unit_found}, 3'b000);

        // 8: conflict at the last index and unit at index 0 together
        fill_default();
        set_clause(63, mk(1, 1), mk(1, 1), mk(0, 0));
        set_clause(0, mk(1, 1), mk(0, 12), mk(0, 0));
        set_clause(48, mk(1, 13), mk(1, 1), mk(0, 0));
        run_full();
        check("t8_both", {conflict, unit_found}, 2'b11);
        check("t8_conflict_idx", conflict_idx, 63);
        check("t8_unit_lit", unit_lit, 9'd12);

        idle(4);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
